// File: rtl/id_ex_stage_pkg.sv
// Shared core definitions for the ID/EX boundary: control bundle, ALU op codes and
// forwarding selects.
package id_ex_stage_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2
  } ForwardSel;

  typedef enum logic [2:0] {
    ALU_NOP  = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_OR   = 3'd4,
    ALU_XOR  = 3'd5,
    ALU_SLT  = 3'd6,
    ALU_PASS = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic    RegWrite;
    logic    MemRead;
    logic    MemWrite;
    logic    Branch;
    alu_op_e ALUOp;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{
    RegWrite: 1'b0,
    MemRead:  1'b0,
    MemWrite: 1'b0,
    Branch:   1'b0,
    ALUOp:    ALU_NOP
  };

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard compare between the load in EX and the instruction in ID.
module load_use_detect #(
  parameter int unsigned REG_W = 3
) (
  input  logic             ex_valid_i,
  input  logic             ex_mem_read_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             id_valid_i,
  input  logic             id_uses_rs_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic             id_uses_rd_i,
  input  logic [REG_W-1:0] id_rd_i,
  output logic             hazard_o
);

  logic src_match;

  // Register 0 is hardwired, so a load targeting it can never feed a consumer.
  assign src_match = (id_uses_rs_i && (id_rs_i == ex_rd_i)) ||
                     (id_uses_rd_i && (id_rd_i == ex_rd_i));
  assign hazard_o  = ex_valid_i && ex_mem_read_i && (ex_rd_i != '0) && id_valid_i && src_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, memory-stall freeze
// and a saturating bubble counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned REG_W  = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ID_Valid,
  input  logic [REG_W-1:0]  ID_Rs,
  input  logic [REG_W-1:0]  ID_Rd,
  input  logic              ID_UsesRs,
  input  logic              ID_UsesRd,
  input  logic [DATA_W-1:0] ID_A,
  input  logic [DATA_W-1:0] ID_B,
  input  logic [DATA_W-1:0] ID_Imm,
  input  ctrl_t             ID_Ctrl,
  input  logic              EX_Flush,
  input  logic              MEM_Stall,
  output logic              EX_Valid,
  output logic [REG_W-1:0]  EX_Rs,
  output logic [REG_W-1:0]  EX_Rd,
  output logic [DATA_W-1:0] EX_A,
  output logic [DATA_W-1:0] EX_B,
  output logic [DATA_W-1:0] EX_Imm,
  output ctrl_t             EX_Ctrl,
  output logic              IF_ID_Hold,
  output logic [CNT_W-1:0]  BubbleCount
);

  logic              valid_q, valid_d;
  logic [REG_W-1:0]  rs_q, rs_d, rd_q, rd_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              load_use;

  load_use_detect #(
    .REG_W (REG_W)
  ) u_load_use_detect (
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (ctrl_q.MemRead),
    .ex_rd_i       (rd_q),
    .id_valid_i    (ID_Valid),
    .id_uses_rs_i  (ID_UsesRs),
    .id_rs_i       (ID_Rs),
    .id_uses_rd_i  (ID_UsesRd),
    .id_rd_i       (ID_Rd),
    .hazard_o      (load_use)
  );

  // A flush clears IF/ID upstream, so only a load-use bubble needs the hold.
  assign IF_ID_Hold = MEM_Stall || (load_use && !EX_Flush);

  always_comb begin
    valid_d = valid_q;
    rs_d    = rs_q;
    rd_d    = rd_q;
    a_d     = a_q;
    b_d     = b_q;
    imm_d   = imm_q;
    ctrl_d  = ctrl_q;
    cnt_d   = cnt_q;
    if (!MEM_Stall) begin
      if (EX_Flush || load_use) begin
        valid_d = 1'b0;
        rs_d    = '0;
        rd_d    = '0;
        a_d     = '0;
        b_d     = '0;
        imm_d   = '0;
        ctrl_d  = CTRL_BUBBLE;
        cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
      end else begin
        valid_d = ID_Valid;
        rs_d    = ID_Rs;
        rd_d    = ID_Rd;
        a_d     = ID_A;
        b_d     = ID_B;
        imm_d   = ID_Imm;
        ctrl_d  = ID_Valid ? ID_Ctrl : CTRL_BUBBLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      rs_q    <= '0;
      rd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      ctrl_q  <= CTRL_BUBBLE;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rs_q    <= rs_d;
      rd_q    <= rd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign EX_Valid    = valid_q;
  assign EX_Rs       = rs_q;
  assign EX_Rd       = rd_q;
  assign EX_A        = a_q;
  assign EX_B        = b_q;
  assign EX_Imm      = imm_q;
  assign EX_Ctrl     = ctrl_q;
  assign BubbleCount = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table for the pipeline flow plus sequences for
// async reset mid-stall and bubble-counter saturation.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [2:0] id_rs = '0, id_rd = '0;
  logic       id_uses_rs = 1'b0, id_uses_rd = 1'b0;
  logic [7:0] id_a = '0, id_b = '0, id_imm = '0;
  ctrl_t      id_ctrl;
  logic       ex_flush = 1'b0, mem_stall = 1'b0;
  logic       ex_valid;
  logic [2:0] ex_rs, ex_rd;
  logic [7:0] ex_a, ex_b, ex_imm;
  ctrl_t      ex_ctrl;
  logic       if_id_hold;
  logic [15:0] bubble_count;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  id_ex_stage #(
    .DATA_W (8),
    .REG_W  (3),
    .CNT_W  (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ID_Valid    (id_valid),
    .ID_Rs       (id_rs),
    .ID_Rd       (id_rd),
    .ID_UsesRs   (id_uses_rs),
    .ID_UsesRd   (id_uses_rd),
    .ID_A        (id_a),
    .ID_B        (id_b),
    .ID_Imm      (id_imm),
    .ID_Ctrl     (id_ctrl),
    .EX_Flush    (ex_flush),
    .MEM_Stall   (mem_stall),
    .EX_Valid    (ex_valid),
    .EX_Rs       (ex_rs),
    .EX_Rd       (ex_rd),
    .EX_A        (ex_a),
    .EX_B        (ex_b),
    .EX_Imm      (ex_imm),
    .EX_Ctrl     (ex_ctrl),
    .IF_ID_Hold  (if_id_hold),
    .BubbleCount (bubble_count)
  );

  localparam ctrl_t C0 = ctrl_t'(7'd0);
  localparam ctrl_t CAD = '{RegWrite: 1'b1, MemRead: 1'b0, MemWrite: 1'b0, Branch: 1'b0,
                            ALUOp: ALU_ADD};
  localparam ctrl_t CLD = '{RegWrite: 1'b1, MemRead: 1'b1, MemWrite: 1'b0, Branch: 1'b0,
                            ALUOp: ALU_ADD};
  localparam ctrl_t CST = '{RegWrite: 1'b0, MemRead: 1'b0, MemWrite: 1'b1, Branch: 1'b0,
                            ALUOp: ALU_ADD};

  typedef struct {
    logic       v;
    logic [2:0] rs, rd;
    logic       urs, urd;
    logic [7:0] a, b, imm;
    ctrl_t      ctrl;
    logic       flush, stall;
    logic       x_hold;
    logic       x_v;
    logic [2:0] x_rs, x_rd;
    logic [7:0] x_a, x_b, x_imm;
    ctrl_t      x_ctrl;
    logic [15:0] x_cnt;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_ex(input string tag, input logic v, input logic [2:0] rs,
                        input logic [2:0] rd, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] imm, input ctrl_t c, input logic [15:0] cnt);
    chk({tag, ".EX_Valid"}, 32'(ex_valid), 32'(v));
    chk({tag, ".EX_Rs"}, 32'(ex_rs), 32'(rs));
    chk({tag, ".EX_Rd"}, 32'(ex_rd), 32'(rd));
    chk({tag, ".EX_A"}, 32'(ex_a), 32'(a));
    chk({tag, ".EX_B"}, 32'(ex_b), 32'(b));
    chk({tag, ".EX_Imm"}, 32'(ex_imm), 32'(imm));
    chk({tag, ".EX_Ctrl"}, 32'(ex_ctrl), 32'(c));
    chk({tag, ".BubbleCount"}, 32'(bubble_count), 32'(cnt));
  endtask

  initial begin
    id_ctrl = C0;
    // Expected values after each edge, hand-derived from the previous EX contents.
    //           v  rs rd urs urd a  b  imm ctrl fl st | hold  v rs rd a b imm ctrl cnt
    vq.push_back('{1, 2, 3, 1, 0, 8'h11, 8'h22, 8'h00, CAD, 0, 0,
                   0, 1, 2, 3, 8'h11, 8'h22, 8'h00, CAD, 16'd0});
    vq.push_back('{1, 1, 3, 1, 0, 8'h05, 8'h00, 8'h04, CLD, 0, 0,
                   0, 1, 1, 3, 8'h05, 8'h00, 8'h04, CLD, 16'd0});
    vq.push_back('{1, 3, 4, 1, 0, 8'h33, 8'h44, 8'h00, CAD, 0, 0,
                   1, 0, 0, 0, 8'h00, 8'h00, 8'h00, C0, 16'd1});
    vq.push_back('{1, 3, 4, 1, 0, 8'h33, 8'h44, 8'h00, CAD, 0, 0,
                   0, 1, 3, 4, 8'h33, 8'h44, 8'h00, CAD, 16'd1});
    vq.push_back('{1, 1, 0, 1, 0, 8'h07, 8'h00, 8'h08, CLD, 0, 0,
                   0, 1, 1, 0, 8'h07, 8'h00, 8'h08, CLD, 16'd1});
    vq.push_back('{1, 0, 5, 1, 0, 8'h55, 8'h01, 8'h00, CAD, 0, 0,
                   0, 1, 0, 5, 8'h55, 8'h01, 8'h00, CAD, 16'd1});
    vq.push_back('{1, 2, 6, 1, 0, 8'h66, 8'h00, 8'h0C, CLD, 0, 0,
                   0, 1, 2, 6, 8'h66, 8'h00, 8'h0C, CLD, 16'd1});
    vq.push_back('{1, 1, 6, 0, 1, 8'h77, 8'h78, 8'h10, CST, 0, 0,
                   1, 0, 0, 0, 8'h00, 8'h00, 8'h00, C0, 16'd2});
    vq.push_back('{1, 1, 6, 0, 1, 8'h77, 8'h78, 8'h10, CST, 0, 0,
                   0, 1, 1, 6, 8'h77, 8'h78, 8'h10, CST, 16'd2});
    vq.push_back('{1, 1, 2, 1, 0, 8'h09, 8'h00, 8'h02, CLD, 0, 0,
                   0, 1, 1, 2, 8'h09, 8'h00, 8'h02, CLD, 16'd2});
    vq.push_back('{1, 2, 3, 1, 0, 8'h99, 8'h99, 8'h99, CAD, 1, 0,
                   0, 0, 0, 0, 8'h00, 8'h00, 8'h00, C0, 16'd3});
    vq.push_back('{0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, CAD, 0, 0,
                   0, 0, 0, 0, 8'h00, 8'h00, 8'h00, C0, 16'd3});
    vq.push_back('{1, 1, 7, 1, 0, 8'h21, 8'h00, 8'h03, CLD, 0, 0,
                   0, 1, 1, 7, 8'h21, 8'h00, 8'h03, CLD, 16'd3});
    vq.push_back('{1, 7, 1, 1, 0, 8'h70, 8'h71, 8'h72, CAD, 1, 1,
                   1, 1, 1, 7, 8'h21, 8'h00, 8'h03, CLD, 16'd3});
    vq.push_back('{1, 7, 1, 1, 0, 8'h70, 8'h71, 8'h72, CAD, 0, 1,
                   1, 1, 1, 7, 8'h21, 8'h00, 8'h03, CLD, 16'd3});
    vq.push_back('{1, 7, 1, 1, 0, 8'h70, 8'h71, 8'h72, CAD, 0, 1,
                   1, 1, 1, 7, 8'h21, 8'h00, 8'h03, CLD, 16'd3});
    vq.push_back('{1, 7, 1, 1, 0, 8'h70, 8'h71, 8'h72, CAD, 0, 0,
                   1, 0, 0, 0, 8'h00, 8'h00, 8'h00, C0, 16'd4});
    vq.push_back('{1, 7, 1, 1, 0, 8'h70, 8'h71, 8'h72, CAD, 0, 0,
                   0, 1, 7, 1, 8'h70, 8'h71, 8'h72, CAD, 16'd4});

    // Reset state
    #12;
    chk_ex("reset", 1'b0, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00, C0, 16'd0);
    chk("reset.IF_ID_Hold", 32'(if_id_hold), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vq[i]) begin
      id_valid   = vq[i].v;
      id_rs      = vq[i].rs;
      id_rd      = vq[i].rd;
      id_uses_rs = vq[i].urs;
      id_uses_rd = vq[i].urd;
      id_a       = vq[i].a;
      id_b       = vq[i].b;
      id_imm     = vq[i].imm;
      id_ctrl    = vq[i].ctrl;
      ex_flush   = vq[i].flush;
      mem_stall  = vq[i].stall;
      #1;
      chk($sformatf("v%0d.IF_ID_Hold", i), 32'(if_id_hold), 32'(vq[i].x_hold));
      @(posedge clk);
      #1;
      chk_ex($sformatf("v%0d", i), vq[i].x_v, vq[i].x_rs, vq[i].x_rd, vq[i].x_a, vq[i].x_b,
             vq[i].x_imm, vq[i].x_ctrl, vq[i].x_cnt);
    end

    // Async reset while stalled: clears before any clock edge.
    mem_stall = 1'b1;
    ex_flush  = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_ex("rst_mid_stall", 1'b0, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00, C0, 16'd0);
    mem_stall = 1'b0;
    id_valid  = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk_ex("rst_release", 1'b0, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00, C0, 16'd0);
    chk("rst_release.IF_ID_Hold", 32'(if_id_hold), 32'd0);

    // Saturation via back-to-back flushes.
    @(negedge clk);
    ex_flush = 1'b1;
    for (int n = 0; n < 65534; n++) @(posedge clk);
    #1;
    chk("sat.pre", 32'(bubble_count), 32'hFFFE);
    chk("sat.flush_hold", 32'(if_id_hold), 32'd0);
    @(posedge clk);
    #1;
    chk("sat.reach", 32'(bubble_count), 32'hFFFF);
    @(posedge clk);
    #1;
    chk("sat.stay", 32'(bubble_count), 32'hFFFF);
    chk("sat.EX_Valid", 32'(ex_valid), 32'd0);
    ex_flush = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the 5-stage core, with load-use hazard detection. It captures decoded operands and control from ID and presents `EX_Rs`, `EX_Rd`, the control bundle and operand data to EX, where the forwarding unit and ALU consume them. It inserts bubbles for load-use hazards and branch flushes, and freezes on memory stalls. It also keeps a saturating count of inserted bubbles for performance readout.

## Interface
- `DATA_W`, default 8: operand/immediate width.
- `REG_W`, default 3: register index width; register 0 is never a hazard source.
- `CNT_W`, default 16: bubble counter width.

- `clk`  in  1  core clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `ID_Valid`  in  1  ID holds a real instruction.
- `ID_Rs`, `ID_Rd`  in  REG_W  register fields from decode.
- `ID_UsesRs`, `ID_UsesRd`  in  1  instruction reads that field as a source.
- `ID_A`, `ID_B`, `ID_Imm`  in  DATA_W  register-file reads and immediate.
- `ID_Ctrl`  in  `ctrl_t`  RegWrite, MemRead, MemWrite, Branch, ALUOp.
- `EX_Flush`  in  1  taken branch resolved in EX this cycle.
- `MEM_Stall`  in  1  data memory busy; freeze the pipe.
- `EX_Valid`  out  1  EX slot holds a real instruction.
- `EX_Rs`, `EX_Rd`  out  REG_W  to forwarding unit.
- `EX_A`, `EX_B`, `EX_Imm`  out  DATA_W  operand data.
- `EX_Ctrl`  out  `ctrl_t`  registered control.
- `IF_ID_Hold`  out  1  upstream IF/ID must hold this cycle (combinational).
- `BubbleCount`  out  CNT_W  saturating count of inserted bubbles.

## Operation
- Load-use hazard (comb): `EX_Valid & EX_Ctrl.MemRead & EX_Rd!=0 & ID_Valid & ((ID_UsesRs & ID_Rs==EX_Rd) | (ID_UsesRd & ID_Rd==EX_Rd))`.
- Next-state priority, highest first:
  - `MEM_Stall`: all registers hold, including `BubbleCount`. `IF_ID_Hold`=1.
  - `EX_Flush`: load bubble. `IF_ID_Hold`=0, because upstream flushes itself. Counter increments.
  - Load-use: load bubble. `IF_ID_Hold`=1. Counter increments.
  - Otherwise: capture all ID inputs. `EX_Valid`<=`ID_Valid`. `IF_ID_Hold`=0.
- Bubble: `EX_Valid`=0; `EX_Ctrl` all-zero (no RegWrite/MemRead/MemWrite/Branch, ALUOp=`ALU_NOP`); `EX_Rs`=`EX_Rd`=0 so forwarding resolves to NONE; data fields 0.
- When `ID_Valid`=0 in normal load, the control fields are also forced to zero, so no side effects leak.
- `BubbleCount` saturates at all-ones and never wraps.

## Timing
- Reset (async assert, sync-to-clk deassert handled upstream): every output register goes to 0 / bubble, and `BubbleCount`=0. `IF_ID_Hold` is then 0, since `EX_Valid`=0.
- Latency: ID inputs appear on EX outputs 1 cycle after a normal-load edge.
- Load-use stall costs exactly one bubble. On the next cycle the EX slot holds the bubble (not MemRead), so the hazard clears and the held ID instruction loads. The forwarding unit then supplies the load data from WB.
- Simultaneous `MEM_Stall` and `EX_Flush`: stall wins, nothing changes. The flush source must hold `EX_Flush` until the stall drops.
- Simultaneous flush and load-use: flush wins, and `IF_ID_Hold`=0.
- `rst_n` low mid-stall clears immediately and does not wait for a clock edge.

## Structure
- `ctrl_t` packed struct, the `ALUOp` enum (including `ALU_NOP`), and a `CTRL_BUBBLE` constant all go in `Defs`, next to `ForwardSel`.
- One sub-module, `load_use_detect` (pure combinational hazard compare). It is reused by the formal hazard checker.
- Register bank and counter stay in `id_ex_stage`.

## Test plan
- Reset: hold `rst_n`=0 mid-stream, then release → `EX_Valid`=0, `EX_Rd`=0, `EX_Ctrl`=0, `BubbleCount`=0, `IF_ID_Hold`=0.
- Normal flow: ID add with Rs=2, Rd=3, A=0x11, B=0x22 → next cycle `EX_Rs`=2, `EX_Rd`=3, `EX_A`=0x11, `EX_Valid`=1.
- Load-use: EX holds load with Rd=3, ID uses Rs=3 → `IF_ID_Hold`=1 for 1 cycle; next EX is a bubble with Rs=Rd=0 and `BubbleCount`=1; the following cycle the ID instruction enters EX.
- Register 0: EX load with Rd=0, ID Rs=0 → no hold, no bubble.
- Flush plus load-use in the same cycle → bubble, `IF_ID_Hold`=0, counter +1. `MEM_Stall` held for 3 cycles → all EX outputs and the counter unchanged and `IF_ID_Hold`=1 throughout.
- Saturation: preload the counter to 0xFFFF via repeated flushes (or force) and add another bubble → it stays at 0xFFFF.
